// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: one digit per SCAN_DIV-clock slot,
// double-buffered load that only swaps at frame boundaries, LZ suppression and PWM dimming.
module seg_scan_ctrl #(
    parameter int DIGITS         = 8,
    parameter int SCAN_DIV       = 20000,
    parameter int PWM_BITS       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   din,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  din_vld,
    output logic                  din_rdy,
    input  logic                  lz_en,
    input  logic [PWM_BITS-1:0]   bright,
    output logic [DIGITS-1:0]     sel,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    // The counter must be at least PWM_BITS wide so the PWM phase slice always exists.
    localparam int CNT_RAW_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W     = (CNT_RAW_W > PWM_BITS) ? CNT_RAW_W : PWM_BITS;
    localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(DIGITS - 1);
    localparam logic [PWM_BITS-1:0] BRIGHT_FULL = '1;

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                slot_end;
    logic                frame_end;
    logic                load;

    logic                full;
    logic [4*DIGITS-1:0] pend_din;
    logic [DIGITS-1:0]   pend_dp;
    logic [DIGITS-1:0]   pend_blank;
    logic [4*DIGITS-1:0] act_din;
    logic [DIGITS-1:0]   act_dp;
    logic [DIGITS-1:0]   act_blank;

    logic [3:0]          nib;
    logic                dp_cur;
    logic                blank_cur;
    logic                suppress_cur;
    logic                zero_tail;
    logic [DIGITS-1:0]   suppress;
    logic                pwm_on;
    logic                lit;
    logic [7:0]          code_low;
    logic [7:0]          seg_on;
    logic [DIGITS-1:0]   sel_on;
    logic                wrap_q;

    function automatic logic [7:0] hex_to_seg_low(input logic [3:0] h);
        case (h)
            4'h0:    return 8'hC0;
            4'h1:    return 8'hF9;
            4'h2:    return 8'hA4;
            4'h3:    return 8'hB0;
            4'h4:    return 8'h99;
            4'h5:    return 8'h92;
            4'h6:    return 8'h82;
            4'h7:    return 8'hF8;
            4'h8:    return 8'h80;
            4'h9:    return 8'h90;
            4'hA:    return 8'h88;
            4'hB:    return 8'h83;
            4'hC:    return 8'hC6;
            4'hD:    return 8'hA1;
            4'hE:    return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign load      = din_vld && !full;
    assign din_rdy   = !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A load landing on the boundary cycle sees full=0 there, so it parks until the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full       <= 1'b0;
            pend_din   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            act_din    <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
        end else begin
            if (frame_end && full) begin
                act_din   <= pend_din;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
            end
            if (load) begin
                pend_din   <= din;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
            end
            if (load) begin
                full <= 1'b1;
            end else if (frame_end) begin
                full <= 1'b0;
            end
        end
    end

    // Walk from the top digit down: a digit is suppressible while everything above it is blank-zero.
    always_comb begin
        zero_tail = 1'b1;
        suppress  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_tail   = zero_tail && (act_din[4*k +: 4] == 4'h0) && !act_dp[k];
            suppress[k] = zero_tail && (k != 0);
        end
    end

    always_comb begin
        nib          = 4'h0;
        dp_cur       = 1'b0;
        blank_cur    = 1'b0;
        suppress_cur = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib          = act_din[4*i +: 4];
                dp_cur       = act_dp[i];
                blank_cur    = act_blank[i];
                suppress_cur = suppress[i];
            end
        end
    end

    always_comb begin
        pwm_on   = (bright == BRIGHT_FULL) || (cnt[PWM_BITS-1:0] < bright);
        lit      = pwm_on && !blank_cur && !(lz_en && suppress_cur);
        code_low = hex_to_seg_low(nib) & {~dp_cur, 7'h7F};
        seg_on   = lit ? ~code_low : 8'h00;
        sel_on   = lit ? (DIGITS'(1) << idx) : '0;
    end

    // frame_done is delayed one extra stage so it lines up with digit 0 on the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= {DIGITS{SEL_ACTIVE_LOW}};
            seg        <= {8{SEG_ACTIVE_LOW}};
            wrap_q     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sel        <= sel_on ^ {DIGITS{SEL_ACTIVE_LOW}};
            seg        <= seg_on ^ {8{SEG_ACTIVE_LOW}};
            wrap_q     <= frame_end;
            frame_done <= wrap_q;
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed seven-segment scan controller. It drives DIGITS common-select digits from a packed hex word, with per-digit decimal point, per-digit blanking, leading-zero suppression, PWM brightness and polarity options. It also has a valid/ready load port with frame-synchronous update, so displayed digits never tear mid-frame. It sits between register/status logic and the board-level digit and segment pins.

## Interface
- DIGITS, 8, number of digits scanned; legal 1..16
- SCAN_DIV, 20000, clocks per digit slot; legal >= 2
- PWM_BITS, 4, brightness resolution; legal 1..8
- SEG_ACTIVE_LOW, 1, 1: segment on = 0; 0: segment on = 1
- SEL_ACTIVE_LOW, 0, 1: digit selected = 0; 0: digit selected = 1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- din  in  4*DIGITS  hex nibbles; nibble i ([4i+3:4i]) belongs to digit i
- dp_in  in  DIGITS  decimal-point enables, bit i for digit i
- blank_in  in  DIGITS  force digit i dark
- din_vld  in  1  load request for din/dp_in/blank_in
- din_rdy  out  1  pending buffer empty; load accepted when din_vld & din_rdy
- lz_en  in  1  leading-zero suppression enable, sampled live
- bright  in  PWM_BITS  brightness, sampled live
- sel  out  DIGITS  one-hot digit select, polarity per SEL_ACTIVE_LOW
- seg  out  8  seg[0]=a … seg[6]=g, seg[7]=dp; polarity per SEG_ACTIVE_LOW
- frame_done  out  1  one-cycle pulse at end of the last digit slot

## Operation
- Two register sets hold {din, dp_in, blank_in}: a pending set plus a full flag, and an active set.
- Handshake: on din_vld & din_rdy, the inputs are captured into the pending set and the full flag sets. din_rdy = !full.
- Frame boundary (slot end with idx = DIGITS-1): if full, the pending set is copied to the active set and full clears.
- A load accepted in the same cycle as the boundary, while pending was empty, waits in pending for the next boundary. There is no bypass.
- Scan counter cnt runs 0..SCAN_DIV-1. At cnt = SCAN_DIV-1, cnt wraps to 0 and idx advances 0..DIGITS-1, wrapping to 0.
- Decode (active-low codes, bit7 = dp off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- If active dp[idx] is set, the dp segment is turned on.
- When SEG_ACTIVE_LOW = 0, all 8 bits of seg are inverted.
- Leading-zero suppression (lz_en = 1): digit k is suppressed if its nibble and dp are 0 for every digit j >= k, and k != 0. Digit 0 is never suppressed.
- PWM: phase = cnt[PWM_BITS-1:0]. Digit is lit iff bright = all-ones OR phase < bright. bright = 0 gives dark.
- Dark digit (blank, suppressed, or PWM off): all sel bits inactive and all seg bits inactive.
- Lit digit: only sel[idx] active, seg = decoded pattern.

## Timing
- Reset values:
  - sel = all inactive, seg = all inactive, frame_done = 0, din_rdy = 1
  - cnt = 0, idx = 0, active set = 0, pending empty
- sel and seg are registered. They reflect the idx/cnt/active state of the previous cycle, so latency is 1 clk and outputs are glitch-free.
- Each digit is presented for exactly SCAN_DIV clocks; one frame = DIGITS*SCAN_DIV clocks.
- frame_done is registered and pulses in the cycle after the boundary edge. That is the same cycle in which sel/seg first show digit 0 of the new frame, with the new active data.
- din_rdy rises in the cycle after the boundary that drains pending.
- Reset asserted mid-frame forces all reset values immediately and discards pending data.
- lz_en, bright and blank changes via load take effect with 1-clk output latency.
- Because bright is not frame-synchronised, a change may alter duty within the current slot.

## Test plan
- **Reset and scan order** (DIGITS=4, SCAN_DIV=8, PWM_BITS=2, bright=3, active 0):
  - During reset: sel=0000, seg=FF.
  - After release: sel steps 0001→0010→0100→1000, 8 clks each, seg=C0, frame_done once per 32 clks.
- **Frame-synchronous load:**
  - Load din=16'h1A2F mid-slot 1: din_rdy drops the next cycle.
  - Digits keep showing C0 until frame_done.
  - Then the outputs show 8E, A4, 88, F9 for digits 0..3.
  - din_rdy returns to 1.
- **Back-pressure:**
  - A second load while full is not accepted (din_rdy=0).
  - A load in the boundary cycle with pending empty displays one frame later.
- **Leading zero, dp, blank:**
  - din=16'h0030, lz_en=1: digits 3 and 2 are dark, digit 1 = B0, digit 0 = C0.
  - Setting dp_in=4'b0100: digit 2 = 40.
  - Setting blank_in[0]: digit 0 is dark.
- **PWM:**
  - bright=1: each slot is lit only when cnt[1:0]=0 (2 of 8 clks).
  - bright=0: always dark.
  - bright=3: lit all 8 clks.
- **Polarity and reset mid-frame:**
  - SEG_ACTIVE_LOW=0, SEL_ACTIVE_LOW=1: digit 0 seg=3F, sel=1110.
  - Assert rst_n mid-slot with pending full: outputs go inactive immediately, and after release the display is 0 with din_rdy=1.
